// File: rtl/turbo_dec_8bit_if.sv
// Byte-stream handshake bundle for the turbo decoder.
// Input beats flow master->slave, decoded results slave->master.
interface turbo_dec_8bit_if;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_corrected;
  logic       out_uncorr;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_byte, in_valid, out_ready,
    input  in_ready, out_data, out_corrected,
    input  out_uncorr, out_valid
  );

  modport slave (
    input  in_byte, in_valid, out_ready,
    output in_ready, out_data, out_corrected,
    output out_uncorr, out_valid
  );
endinterface

// File: rtl/turbo_dec_8bit.sv
// Turbo word checker: two-beat frame in, single-error-corrected byte out.
// Keeps saturating counts of corrected and uncorrectable frames.
module turbo_dec_8bit #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  turbo_dec_8bit_if.slave  bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_corr,
  output logic [CNT_W-1:0] cnt_uncorr
);

  typedef enum logic [1:0] {
    S_DATA, S_PAR, S_EVAL, S_OUT
  } state_t;

  localparam logic [CNT_W-1:0] ONE = 1;

  state_t           state_q;
  logic [7:0]       data_q;
  logic [7:0]       par_q;
  logic [7:0]       out_data_q;
  logic             corr_q;
  logic             uncorr_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] cnt_corr_q;
  logic [CNT_W-1:0] cnt_uncorr_q;

  logic [3:0] c;
  logic [3:0] s1;
  logic [3:0] s2;
  logic [7:0] flip;
  logic [7:0] dec_data_d;
  logic       dec_corr_d;
  logic       dec_uncorr_d;

  function automatic logic [3:0] cfn(
    input logic [7:0] d
  );
    cfn[0] = d[0] ^ d[1] ^ d[2];
    cfn[1] = d[2] ^ d[3] ^ d[4];
    cfn[2] = d[4] ^ d[5] ^ d[6];
    cfn[3] = d[6] ^ d[7] ^ d[0];
  endfunction

  function automatic logic one_hot4(
    input logic [3:0] x
  );
    one_hot4 = (x != 4'd0) &&
               ((x & (x - 4'd1)) == 4'd0);
  endfunction

  always_comb begin
    c    = cfn(data_q);
    s1   = c ^ par_q[7:4];
    s2   = c ^ par_q[3:0];
    flip = 8'h00;
    case (s1)
      4'b1001: flip = 8'h01;
      4'b0001: flip = 8'h02;
      4'b0011: flip = 8'h04;
      4'b0010: flip = 8'h08;
      4'b0110: flip = 8'h10;
      4'b0100: flip = 8'h20;
      4'b1100: flip = 8'h40;
      4'b1000: flip = 8'h80;
      default: flip = 8'h00;
    endcase
    dec_data_d   = data_q;
    dec_corr_d   = 1'b0;
    dec_uncorr_d = 1'b0;
    unique case (1'b1)
      (s1 == 4'd0) && (s2 == 4'd0): ;
      (s1 == s2) && (flip != 8'h00): begin
        dec_data_d = data_q ^ flip;
        dec_corr_d = 1'b1;
      end
      (s1 == 4'd0) && one_hot4(s2),
      (s2 == 4'd0) && one_hot4(s1):
        dec_corr_d = 1'b1;
      default:
        dec_uncorr_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_DATA;
      data_q       <= 8'h00;
      par_q        <= 8'h00;
      out_data_q   <= 8'h00;
      corr_q       <= 1'b0;
      uncorr_q     <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else begin
      unique case (state_q)
        S_DATA: if (bus.in_valid) begin
          data_q  <= bus.in_byte;
          state_q <= S_PAR;
        end
        S_PAR: if (bus.in_valid) begin
          par_q      <= bus.in_byte;
          in_ready_q <= 1'b0;
          state_q    <= S_EVAL;
        end
        S_EVAL: begin
          out_data_q  <= dec_data_d;
          corr_q      <= dec_corr_d;
          uncorr_q    <= dec_uncorr_d;
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_DATA;
        end
        default: state_q <= S_DATA;
      endcase
      // clear has priority over a same-cycle increment
      if (cnt_clr) begin
        cnt_corr_q   <= '0;
        cnt_uncorr_q <= '0;
      end else if (state_q == S_EVAL) begin
        if (dec_corr_d && !(&cnt_corr_q))
          cnt_corr_q <= cnt_corr_q + ONE;
        if (dec_uncorr_d && !(&cnt_uncorr_q))
          cnt_uncorr_q <= cnt_uncorr_q + ONE;
      end
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_corrected = corr_q;
  assign bus.out_uncorr    = uncorr_q;
  assign cnt_corr          = cnt_corr_q;
  assign cnt_uncorr        = cnt_uncorr_q;

endmodule

// File: tb/tb_turbo_dec_8bit.sv
// Scoreboard bench for turbo_dec_8bit with CNT_W=2.
// Expected results are queued at issue and checked on output handshake.
module tb_turbo_dec_8bit;

  localparam int CW = 2;

  typedef struct packed {
    logic [7:0] data;
    logic       corr;
    logic       uncorr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cnt_clr;
  logic [CW-1:0] cnt_corr;
  logic [CW-1:0] cnt_uncorr;

  turbo_dec_8bit_if bus ();

  turbo_dec_8bit #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .cnt_clr    (cnt_clr),
    .cnt_corr   (cnt_corr),
    .cnt_uncorr (cnt_uncorr)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got %0h expected none",
                 bus.out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", {24'd0, bus.out_data}, {24'd0, e.data});
        chk("out_corrected", {31'd0, bus.out_corrected},
            {31'd0, e.corr});
        chk("out_uncorr", {31'd0, bus.out_uncorr},
            {31'd0, e.uncorr});
      end
    end
  end

  task automatic beat(input logic [7:0] b);
    int n;
    n = 0;
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic push(
    input logic [7:0] d,
    input logic       co,
    input logic       un
  );
    exp_t e;
    e.data   = d;
    e.corr   = co;
    e.uncorr = un;
    sb.push_back(e);
  endtask

  task automatic frame(
    input logic [7:0] d,
    input logic [7:0] p,
    input logic [7:0] ed,
    input logic       co,
    input logic       un
  );
    push(ed, co, un);
    beat(d);
    beat(p);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cnts(
    input string         tag,
    input logic [CW-1:0] ec,
    input logic [CW-1:0] eu
  );
    chk({tag, "_cnt_corr"}, {30'd0, cnt_corr}, {30'd0, ec});
    chk({tag, "_cnt_uncorr"}, {30'd0, cnt_uncorr}, {30'd0, eu});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1);
  end

  initial begin
    logic [7:0] sat_data [5];
    sat_data = '{8'hA4, 8'hA7, 8'hA1, 8'h25, 8'hAD};

    rst_n         = 1'b0;
    cnt_clr       = 1'b0;
    bus.in_byte   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_data", {24'd0, bus.out_data}, 32'd0);
    cnts("rst", 2'd0, 2'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // clean frame with latency check
    push(8'hA5, 1'b0, 1'b0);
    beat(8'hA5);
    beat(8'h66);
    chk("lat_eval_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("lat_eval_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("lat_out_valid", {31'd0, bus.out_valid}, 32'd1);
    drain();
    cnts("clean", 2'd0, 2'd0);

    frame(8'hA4, 8'h66, 8'hA5, 1'b1, 1'b0);
    drain();
    cnts("data_err", 2'd1, 2'd0);

    frame(8'hA5, 8'h67, 8'hA5, 1'b1, 1'b0);
    drain();
    cnts("par_err", 2'd2, 2'd0);

    frame(8'hA5, 8'h65, 8'hA5, 1'b0, 1'b1);
    drain();
    cnts("uncorr", 2'd2, 2'd1);
    chk("hold_after_hs", {24'd0, bus.out_data, 7'd0, bus.out_uncorr},
        {24'd0, 8'hA5, 7'd0, 1'b1});

    // backpressure with in_valid held high
    bus.out_ready = 1'b0;
    frame(8'hA4, 8'h66, 8'hA5, 1'b1, 1'b0);
    bus.in_byte  = 8'hFF;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_out_data", {24'd0, bus.out_data}, 32'hA5);
      chk("bp_corr", {31'd0, bus.out_corrected}, 32'd1);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    cnts("bp", 2'd3, 2'd1);
    frame(8'hA5, 8'h66, 8'hA5, 1'b0, 1'b0);
    drain();

    // standalone clear
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    cnts("clr", 2'd0, 2'd0);

    for (int i = 0; i < 5; i++) begin
      frame(sat_data[i], 8'h66, 8'hA5, 1'b1, 1'b0);
      drain();
      if (i == 2) cnts("sat3", 2'd3, 2'd0);
    end
    cnts("sat5", 2'd3, 2'd0);

    frame(8'hA5, 8'h65, 8'hA5, 1'b0, 1'b1);
    drain();
    cnts("pre_clr", 2'd3, 2'd1);

    // clear coincides with the S_EVAL increment
    push(8'hA5, 1'b0, 1'b1);
    beat(8'hA5);
    beat(8'h65);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    drain();
    cnts("clr_eval", 2'd0, 2'd0);

    frame(8'h25, 8'h66, 8'hA5, 1'b1, 1'b0);
    drain();
    cnts("pre_rst", 2'd1, 2'd0);

    // reset in the middle of a frame
    beat(8'hA4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_data", {24'd0, bus.out_data}, 32'd0);
    chk("mid_rst_flags", {30'd0, bus.out_corrected, bus.out_uncorr},
        32'd0);
    cnts("mid_rst", 2'd0, 2'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", {31'd0, bus.in_ready}, 32'd1);
    frame(8'hA5, 8'h66, 8'hA5, 1'b0, 1'b0);
    drain();
    cnts("post_rst", 2'd0, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
